// File: rtl/display_timer_bank_pkg.sv
// Shared types and helpers for the display timer bank.
//   timer_state_e : per-channel timer state (IDLE, RUN, PAUSED)
//   sel_width()   : readback select width for a given channel count (min 1)
package display_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } timer_state_e;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/display_timer_bank_if.sv
// Control/status bundle between the display sequencer (master) and the
// timer bank (slave).
//   start/cancel/pause/periodic : per-channel controls from the sequencer
//   duration                    : shared tick count sampled on start
//   rd_sel/rd_count             : count readback
//   busy/expire/any_expire      : per-channel status towards the renderer
interface display_timer_bank_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 32
);
  import display_timer_pkg::*;

  localparam int unsigned SEL_W = sel_width(NUM_CH);

  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] cancel;
  logic [NUM_CH-1:0] pause;
  logic [NUM_CH-1:0] periodic;
  logic [WIDTH-1:0]  duration;
  logic [SEL_W-1:0]  rd_sel;
  logic [WIDTH-1:0]  rd_count;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] expire;
  logic              any_expire;

  modport master (
    output start, cancel, pause, periodic, duration, rd_sel,
    input  rd_count, busy, expire, any_expire
  );

  modport slave (
    input  start, cancel, pause, periodic, duration, rd_sel,
    output rd_count, busy, expire, any_expire
  );

endinterface

// File: rtl/display_timer_bank_channel.sv
// One display-duration timer channel: state machine plus down-counter.
//   clk, reset : clock, asynchronous active-high reset
//   tick       : prescaled count enable
//   start      : load duration and run (restart in any state)
//   cancel     : abort to IDLE, no expiry
//   pause      : level, holds the count while high
//   periodic   : auto-reload mode, sampled on start
//   duration   : tick count sampled on start
//   count      : remaining count
//   busy       : registered, channel is RUN or PAUSED
//   expire     : registered one-cycle expiry pulse
module display_timer_channel
  import display_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             cancel,
  input  logic             pause,
  input  logic             periodic,
  input  logic [WIDTH-1:0] duration,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expire
);

  timer_state_e     state;
  logic [WIDTH-1:0] reload;
  logic             mode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      mode   <= 1'b0;
      busy   <= 1'b0;
      expire <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (cancel) begin
        state <= IDLE;
        count <= '0;
        busy  <= 1'b0;
      end else if (start) begin
        count  <= duration;
        reload <= duration;
        mode   <= periodic;
        state  <= pause ? PAUSED : RUN;
        busy   <= 1'b1;
      end else begin
        case (state)
          RUN, PAUSED: begin
            // Leaving PAUSED acts on the tick in the same cycle, so the
            // count is held for exactly the cycles pause is high.
            if (pause) begin
              state <= PAUSED;
            end else begin
              state <= RUN;
              if (tick) begin
                if (count > WIDTH'(1)) begin
                  count <= count - 1'b1;
                end else begin
                  expire <= 1'b1;
                  if (mode) begin
                    count <= (reload == '0) ? WIDTH'(1) : reload;
                  end else begin
                    state <= IDLE;
                    count <= '0;
                    busy  <= 1'b0;
                  end
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/display_timer_bank.sv
// Bank of independent display-duration timers with a shared prescaler.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of display_timer_bank_if (controls, duration,
//                readback select/count, busy/expire/any_expire)
// PRESCALE clocks make one timer tick; PRESCALE=1 ticks every clock.
module display_timer_bank
  import display_timer_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  display_timer_bank_if.slave  bus
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]    pre_cnt;
  logic             tick;
  logic [WIDTH-1:0] cnt [NUM_CH];

  assign tick = (pre_cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    display_timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .start    (bus.start[g]),
      .cancel   (bus.cancel[g]),
      .pause    (bus.pause[g]),
      .periodic (bus.periodic[g]),
      .duration (bus.duration),
      .count    (cnt[g]),
      .busy     (bus.busy[g]),
      .expire   (bus.expire[g])
    );
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    bus.rd_count = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(bus.rd_sel) == i) bus.rd_count = cnt[i];
    end
  end

  assign bus.any_expire = |bus.expire;

endmodule

// File: tb/tb_display_timer_bank.sv
// Self-checking bench: two banks (4 ch / PRESCALE 1, 3 ch / PRESCALE 4) share
// one stimulus stream; a behavioural model predicts busy, expire, any_expire
// and readback every cycle.
module tb_display_timer_bank;

  localparam int unsigned WIDTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]       st, cn, pa, pe;
  logic [WIDTH-1:0] dur;
  logic [1:0]       sel;

  display_timer_bank_if #(.NUM_CH(4), .WIDTH(WIDTH)) bus_a ();
  display_timer_bank_if #(.NUM_CH(3), .WIDTH(WIDTH)) bus_b ();

  assign bus_a.start    = st;
  assign bus_a.cancel   = cn;
  assign bus_a.pause    = pa;
  assign bus_a.periodic = pe;
  assign bus_a.duration = dur;
  assign bus_a.rd_sel   = sel;
  assign bus_b.start    = st[2:0];
  assign bus_b.cancel   = cn[2:0];
  assign bus_b.pause    = pa[2:0];
  assign bus_b.periodic = pe[2:0];
  assign bus_b.duration = dur;
  assign bus_b.rd_sel   = sel;

  display_timer_bank #(.NUM_CH(4), .WIDTH(WIDTH), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  display_timer_bank #(.NUM_CH(3), .WIDTH(WIDTH), .PRESCALE(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  // Reference model: per instance k, per channel c.
  int unsigned NCH [2] = '{4, 3};
  int unsigned PS  [2] = '{1, 4};
  int unsigned m_cnt [2][4];
  int unsigned m_rel [2][4];
  bit          m_act [2][4];
  bit          m_mode[2][4];
  bit          m_exp [2][4];
  int unsigned edge_n;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++) begin
        m_cnt[k][c] = 0; m_rel[k][c] = 0; m_act[k][c] = 0;
        m_mode[k][c] = 0; m_exp[k][c] = 0;
      end
    edge_n = 0;
  endtask

  // One clock edge: cancel beats start; start loads; otherwise an active,
  // unpaused channel consumes a tick.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit tk;
      tk = ((edge_n % PS[k]) == PS[k] - 1);
      for (int c = 0; c < int'(NCH[k]); c++) begin
        m_exp[k][c] = 0;
        if (cn[c]) begin
          m_act[k][c] = 0; m_cnt[k][c] = 0;
        end else if (st[c]) begin
          m_cnt[k][c] = dur; m_rel[k][c] = dur;
          m_mode[k][c] = pe[c]; m_act[k][c] = 1;
        end else if (m_act[k][c] && !pa[c] && tk) begin
          if (m_cnt[k][c] > 1) m_cnt[k][c] = m_cnt[k][c] - 1;
          else begin
            m_exp[k][c] = 1;
            if (m_mode[k][c]) m_cnt[k][c] = (m_rel[k][c] == 0) ? 1 : m_rel[k][c];
            else begin m_act[k][c] = 0; m_cnt[k][c] = 0; end
          end
        end
      end
    end
    edge_n++;
  endtask

  function automatic logic [3:0] exp_vec(input int k, input bit want_busy);
    logic [3:0] v = '0;
    for (int c = 0; c < int'(NCH[k]); c++) v[c] = want_busy ? m_act[k][c] : m_exp[k][c];
    return v;
  endfunction

  function automatic int unsigned exp_rd(input int k);
    return (int'(sel) < int'(NCH[k])) ? m_cnt[k][sel] : 0;
  endfunction

  task automatic check_all();
    check("a.busy",   bus_a.busy,       exp_vec(0, 1));
    check("a.expire", bus_a.expire,     exp_vec(0, 0));
    check("a.any",    bus_a.any_expire, |exp_vec(0, 0));
    check("a.rd",     bus_a.rd_count,   exp_rd(0));
    check("b.busy",   bus_b.busy,       exp_vec(1, 1));
    check("b.expire", bus_b.expire,     exp_vec(1, 0));
    check("b.any",    bus_b.any_expire, |exp_vec(1, 0));
    check("b.rd",     bus_b.rd_count,   exp_rd(1));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    check_all();
  endtask

  // Apply inputs for the next edge, then take that edge.
  task automatic cyc(input logic [3:0] s, input logic [3:0] c, input logic [3:0] p,
                     input logic [3:0] per, input int unsigned d);
    st = s; cn = c; pa = p; pe = per; dur = WIDTH'(d);
    step();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      sel = 2'($urandom_range(3));
      cyc(4'h0, 4'h0, 4'h0, 4'h0, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    st = '0; cn = '0; pa = '0; pe = '0; dur = '0; sel = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // One-shot, duration 3, watched on channel 0.
    sel = 2'd0;
    cyc(4'h1, 4'h0, 4'h0, 4'h0, 3);
    for (int i = 0; i < 8; i++) cyc(4'h0, 4'h0, 4'h0, 4'h0, 0);

    // Periodic channel 2, then cancel.
    sel = 2'd2;
    cyc(4'h4, 4'h0, 4'h0, 4'h4, 5);
    for (int i = 0; i < 22; i++) cyc(4'h0, 4'h0, 4'h0, 4'h0, 0);
    cyc(4'h0, 4'h4, 4'h0, 4'h0, 0);
    for (int i = 0; i < 6; i++) cyc(4'h0, 4'h0, 4'h0, 4'h0, 0);

    // Pause channel 0 at count 6 for 7 cycles.
    sel = 2'd0;
    cyc(4'h1, 4'h0, 4'h0, 4'h0, 10);
    for (int i = 0; i < 4; i++) cyc(4'h0, 4'h0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 7; i++) cyc(4'h0, 4'h0, 4'h1, 4'h0, 0);
    for (int i = 0; i < 15; i++) cyc(4'h0, 4'h0, 4'h0, 4'h0, 0);

    // Start+cancel together on channel 3; restart channel 0 mid-run.
    sel = 2'd3;
    cyc(4'h8, 4'h8, 4'h0, 4'h0, 5);
    for (int i = 0; i < 3; i++) cyc(4'h0, 4'h0, 4'h0, 4'h0, 0);
    sel = 2'd0;
    cyc(4'h1, 4'h0, 4'h0, 4'h0, 9);
    for (int i = 0; i < 7; i++) cyc(4'h0, 4'h0, 4'h0, 4'h0, 0);
    cyc(4'h1, 4'h0, 4'h0, 4'h0, 8);
    for (int i = 0; i < 12; i++) cyc(4'h0, 4'h0, 4'h0, 4'h0, 0);

    // Reset in the middle of counting on every channel.
    cyc(4'hF, 4'h0, 4'h0, 4'h5, 20);
    idle(5);
    do_reset();

    // Durations 0 and 1, one-shot and periodic.
    sel = 2'd1;
    cyc(4'h1, 4'h0, 4'h0, 4'h0, 0);
    idle(3);
    cyc(4'h2, 4'h0, 4'h0, 4'h2, 0);
    idle(10);
    cyc(4'h3, 4'h0, 4'h0, 4'h0, 1);
    idle(10);
    cyc(4'h0, 4'h2, 4'h0, 4'h0, 0);
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] s, c, p;
      for (int b = 0; b < 4; b++) begin
        s[b] = ($urandom_range(9) == 0);
        c[b] = ($urandom_range(40) == 0);
        p[b] = ($urandom_range(5) == 0) ? ~pa[b] : pa[b];
      end
      sel = 2'($urandom_range(3));
      cyc(s, c, p, 4'($urandom), ($urandom_range(15) == 0) ? $urandom_range(60) : $urandom_range(12));
      if (i == 1500) do_reset();
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
